// File: rtl/dmem_responder_pkg.sv
// Shared widths, memory opcode encodings and FSM states for the data-memory responder.
package dmem_responder_pkg;

    localparam int unsigned CPU_WIDTH    = 32;
    localparam int unsigned MEM_OP_WIDTH = 4;

    typedef enum logic [MEM_OP_WIDTH-1:0] {
        MEM_NO  = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StRsp  = 2'd2
    } state_e;

    function automatic logic is_load(input mem_op_e op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

endpackage

// File: rtl/dmem_responder_load_extract.sv
// Byte/half/word selection from a 32-bit word with sign or zero extension.
module dmem_responder_load_extract
    import dmem_responder_pkg::*;
(
    input  mem_op_e              op_i,
    input  logic [1:0]           addr_lo_i,
    input  logic [CPU_WIDTH-1:0] word_i,
    output logic [CPU_WIDTH-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = '0;
        case (op_i)
            MEM_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: data_o = {24'd0, byte_sel};
            MEM_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: data_o = {16'd0, half_sel};
            MEM_LW:  data_o = word_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, one-cycle RAM access, held valid/ready response out.
// Optional DMEM_ALIGN_CHECK_EN enables misalignment and out-of-range error detection.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [MEM_OP_WIDTH-1:0] req_op_i,
    input  logic [CPU_WIDTH-1:0]    req_addr_i,
    input  logic [CPU_WIDTH-1:0]    req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [CPU_WIDTH-1:0]    rsp_rdata_o,
    output logic [CPU_WIDTH-1:0]    rsp_raw_o,
    output logic                    rsp_err_o
);

    state_e               state_q;
    mem_op_e              op_q;
    logic [CPU_WIDTH-1:0] addr_q;
    logic [CPU_WIDTH-1:0] wdata_q;
    logic                 rsp_valid_q;
    logic [CPU_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [CPU_WIDTH-1:0] rsp_raw_q, rsp_raw_d;
    logic                 rsp_err_q, rsp_err_d;

    logic [CPU_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]        idx;
    logic [CPU_WIDTH-1:0] word;
    logic [CPU_WIDTH-1:0] ext_data;
    logic                 mem_we;
    logic                 is_mem;

    assign idx    = addr_q[AW+1:2];
    assign word   = mem_q[idx];
    assign is_mem = is_load(op_q) || is_store(op_q);

`ifdef DMEM_ALIGN_CHECK_EN
    logic misal;
    logic oor;

    always_comb begin
        misal = 1'b0;
        case (op_q)
            MEM_LH, MEM_LHU, MEM_SH: misal = addr_q[0];
            MEM_LW, MEM_SW:          misal = |addr_q[1:0];
            default:                 misal = 1'b0;
        endcase
    end

    assign oor       = |addr_q[CPU_WIDTH-1:AW+2];
    assign rsp_err_d = is_mem && (misal || oor);
`else
    // Without checking, low bits are ignored by word indexing and upper bits simply wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[CPU_WIDTH-1:AW+2];
    assign rsp_err_d      = 1'b0;
`endif

    dmem_responder_load_extract u_load_extract (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .word_i    (word),
        .data_o    (ext_data)
    );

    assign rsp_rdata_d = (is_load(op_q) && !rsp_err_d) ? ext_data : '0;
    assign rsp_raw_d   = (is_mem && !rsp_err_d) ? word : '0;

    // Gated by the reset-cleared state, so a reset during ACC suppresses the write.
    assign mem_we = (state_q == StAcc) && is_store(op_q) && !rsp_err_d;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            op_q        <= MEM_NO;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_raw_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        op_q    <= mem_op_e'(req_op_i);
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        state_q <= StAcc;
                    end
                end
                StAcc: begin
                    rsp_rdata_q <= rsp_rdata_d;
                    rsp_raw_q   <= rsp_raw_d;
                    rsp_err_q   <= rsp_err_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StRsp;
                end
                StRsp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_raw_o   = rsp_raw_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
